pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register replacing the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a valid bit, a control field and a data field, with a valid/ready handshake and a synchronous flush. An optional 2-entry skid buffer gives a registered in_ready. Control bits are forced to zero whenever the stage holds no valid beat, so a bubble can never write a register or memory. Stall and flush statistics counters feed the CPU debug block.

---
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush,
// optional two-entry skid buffer and stall/flush statistics.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic              accept;
    logic              issue;
    logic [1:0]        drop;
    logic [CNT_W:0]    fsum;

    assign accept    = in_valid & in_ready;
    assign issue     = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    generate
        if (SKID != 0) begin : g_skid
            logic              s_vld;
            logic [CTRL_W-1:0] s_ctrl;
            logic [DATA_W-1:0] s_data;

            // Ready comes from the skid flag only, never from out_ready.
            assign in_ready = ~s_vld & ~reset;
            assign s_valid  = s_vld;

            always_ff @(posedge clock) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                    s_vld   <= 1'b0;
                    s_ctrl  <= '0;
                    s_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    s_vld   <= 1'b0;
                    s_ctrl  <= '0;
                end else if (issue) begin
                    if (s_vld) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= s_ctrl;
                        m_data  <= s_data;
                        s_vld   <= 1'b0;
                        s_ctrl  <= '0;
                    end else if (accept) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= in_ctrl;
                        m_data  <= in_data;
                    end else begin
                        m_valid <= 1'b0;
                        m_ctrl  <= '0;
                    end
                end else if (accept) begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= in_ctrl;
                        m_data  <= in_data;
                    end else begin
                        s_vld  <= 1'b1;
                        s_ctrl <= in_ctrl;
                        s_data <= in_data;
                    end
                end
            end
        end else begin : g_single
            assign in_ready = (~m_valid | out_ready) & ~reset;
            assign s_valid  = 1'b0;

            always_ff @(posedge clock) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end else if (accept) begin
                    m_valid <= 1'b1;
                    m_ctrl  <= in_ctrl;
                    m_data  <= in_data;
                end else if (issue) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end
            end
        end
    endgenerate

    // A beat issued in the flush cycle was delivered, so it is not a drop.
    assign drop = 2'(m_valid & ~out_ready) + 2'(s_valid) + 2'(accept);
    assign fsum = {1'b0, flush_cnt} + (CNT_W+1)'(drop);

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (m_valid && !out_ready && !flush && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush)
                flush_cnt <= fsum[CNT_W] ? '1 : fsum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, single-entry and
// narrow-counter instances.
module tb_pipe_stage_reg;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_ctrl = '0;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_ctrl;
    logic [63:0] out_data;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        c4_in_ready;
    logic        c4_out_valid;
    logic [7:0]  c4_out_ctrl;
    logic [63:0] c4_out_data;
    logic [1:0]  c4_occupancy;
    logic [3:0]  c4_stall_cnt;
    logic [3:0]  c4_flush_cnt;

    logic        s0_in_valid = 1'b0;
    logic        s0_in_ready;
    logic [7:0]  s0_in_ctrl = '0;
    logic [63:0] s0_in_data = '0;
    logic        s0_out_valid;
    logic        s0_out_ready = 1'b0;
    logic [7:0]  s0_out_ctrl;
    logic [63:0] s0_out_data;
    logic [1:0]  s0_occupancy;
    logic [15:0] s0_stall_cnt;
    logic [15:0] s0_flush_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .flush(flush), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_c4 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(c4_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(c4_out_valid), .out_ready(out_ready),
        .out_ctrl(c4_out_ctrl), .out_data(c4_out_data),
        .flush(flush), .occupancy(c4_occupancy),
        .stall_cnt(c4_stall_cnt), .flush_cnt(c4_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_s0 (
        .clock(clock), .reset(reset),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .in_ctrl(s0_in_ctrl), .in_data(s0_in_data),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready),
        .out_ctrl(s0_out_ctrl), .out_data(s0_out_data),
        .flush(1'b0), .occupancy(s0_occupancy),
        .stall_cnt(s0_stall_cnt), .flush_cnt(s0_flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [63:0] q[$];
    int sent;
    int recv;
    logic exp_rdy;

    initial begin
        // reset held for two cycles
        in_valid = 1'b1;
        in_ctrl  = 8'h81;
        in_data  = 64'h99;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_flush", flush_cnt, 0);
        check("rst_s0_ready", s0_in_ready, 0);

        // streaming at one beat per cycle
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 8'h81;
            in_data  = 64'h11 + 64'(i);
            #1;
            check("str_in_ready", in_ready, 1);
            tick();
            check("str_valid", out_valid, 1);
            check("str_data", out_data, 64'h11 + 64'(i));
            check("str_ctrl", out_ctrl, 8'h81);
        end
        in_valid = 1'b0;
        tick();
        check("str_end_valid", out_valid, 0);
        check("str_end_ctrl", out_ctrl, 0);
        check("str_stall", stall_cnt, 0);

        // backpressure fills M then S
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h01; in_data = 64'hA1;
        tick();
        check("bp_a_occ", occupancy, 1);
        check("bp_a_ready", in_ready, 1);
        in_ctrl = 8'h02; in_data = 64'hB2;
        tick();
        check("bp_b_ready", in_ready, 0);
        check("bp_b_occ", occupancy, 2);
        check("bp_b_data", out_data, 64'hA1);
        in_ctrl = 8'h03; in_data = 64'hC3;
        tick();
        check("bp_c_held_occ", occupancy, 2);
        check("bp_c_ready", in_ready, 0);
        check("bp_c_data", out_data, 64'hA1);
        check("bp_stall", stall_cnt, 2);
        out_ready = 1'b1;
        tick();
        check("bp_out_b", out_data, 64'hB2);
        check("bp_out_b_ctrl", out_ctrl, 8'h02);
        check("bp_ready_back", in_ready, 1);
        check("bp_occ1", occupancy, 1);
        tick();
        check("bp_out_c", out_data, 64'hC3);
        check("bp_out_c_ctrl", out_ctrl, 8'h03);
        in_valid = 1'b0;
        tick();
        check("bp_drain", out_valid, 0);
        check("bp_stall_final", stall_cnt, 2);

        // flush with both entries held, incoming beat blocked
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h11; in_data = 64'hD1;
        tick();
        in_ctrl = 8'h12; in_data = 64'hD2;
        tick();
        check("fl_occ2", occupancy, 2);
        in_ctrl = 8'h13; in_data = 64'hD3;
        flush = 1'b1;
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_ctrl", out_ctrl, 0);
        check("fl_occ", occupancy, 0);
        check("fl_cnt2", flush_cnt, 2);
        check("fl_stall", stall_cnt, 3);
        // accepted beat killed by flush still counts
        tick();
        check("fl_acc_valid", out_valid, 0);
        check("fl_cnt3", flush_cnt, 3);
        flush = 1'b0;
        out_ready = 1'b1;
        in_ctrl = 8'h5A; in_data = 64'hD0;
        tick();
        check("fl_d_valid", out_valid, 1);
        check("fl_d_data", out_data, 64'hD0);
        check("fl_d_ctrl", out_ctrl, 8'h5A);
        // issue in the flush cycle is delivered, not dropped
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_iss_valid", out_valid, 0);
        check("fl_iss_cnt", flush_cnt, 3);

        // bubble keeps ctrl at zero
        in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 64'hAA;
        tick();
        check("bub_valid", out_valid, 1);
        check("bub_ctrl_ff", out_ctrl, 8'hFF);
        check("bub_data", out_data, 64'hAA);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bub_idle_valid", out_valid, 0);
            check("bub_idle_ctrl", out_ctrl, 0);
        end

        // single-entry instance with toggling out_ready
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 200 && recv < 20; cyc++) begin
            s0_out_ready = (cyc % 2) == 0;
            s0_in_valid  = sent < 20;
            s0_in_ctrl   = 8'h40;
            s0_in_data   = 64'h100 + 64'(sent);
            #1;
            exp_rdy = (q.size() == 0) || s0_out_ready;
            check("s0_ready", s0_in_ready, exp_rdy);
            check("s0_valid", s0_out_valid, q.size() != 0);
            check("s0_occ_max", s0_occupancy > 2'd1, 0);
            if (s0_out_valid && s0_out_ready && q.size() != 0) begin
                check("s0_data", s0_out_data, q[0]);
                void'(q.pop_front());
                recv++;
            end
            if (s0_in_valid && s0_in_ready) begin
                q.push_back(s0_in_data);
                sent++;
            end
            tick();
        end
        check("s0_recv", recv, 20);
        check("s0_sent", sent, 20);
        s0_in_valid = 1'b0;

        // narrow counter saturates after 20 stall cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h07; in_data = 64'hE0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_c4", c4_stall_cnt, 15);
        check("sat_main", stall_cnt, 20);
        tick();
        check("sat_c4_hold", c4_stall_cnt, 15);
        reset = 1'b1;
        tick();
        check("sat_c4_rst", c4_stall_cnt, 0);
        check("sat_main_rst", stall_cnt, 0);
        check("sat_rst_valid", out_valid, 0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
